row_sequencer: RTL and testbench

Parametrised row/position sequencer for the tower-stacking game: tracks the current row, generates the row's Y pixel, sweeps the moving block's X position across the row on each movement tick, and advances to the next row when the player drops. It sits between the game control FSM (start/drop/step) and the draw datapath (x/y/direction). It replaces the fixed seven-row lookup with configurable geometry, autonomous horizontal motion and a tower-complete indication.

---
 rtl/tob_pkg.sv | 18 +
 rtl/row_seq_stepper.sv | 51 +++++
 rtl/row_sequencer.sv | 131 +++++++++++++
 tb/tb_row_sequencer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/tob_pkg.sv
// Shared definitions for the tower-stacking game: sweep directions,
// row sequencer state encoding and screen geometry.
package tob_pkg;

  localparam logic GO_LEFT  = 1'b0;
  localparam logic GO_RIGHT = 1'b1;

  localparam int SCREEN_WIDTH  = 160;
  localparam int SCREEN_HEIGHT = 120;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MOVE    = 2'd1,
    ADVANCE = 2'd2,
    DONE    = 2'd3
  } row_seq_state_t;

endpackage

// File: rtl/row_seq_stepper.sv
// Combinational next-X / next-direction for one movement tick.
// ROW_SEQ_BOUNCE_EN selects clamp-and-reverse at the limits; default is wrap-around.
module row_seq_stepper
  import tob_pkg::*;
#(
  parameter int X_MIN  = 0,
  parameter int X_MAX  = 144,
  parameter int X_STEP = 4
) (
  input  logic [7:0] i_x,
  input  logic       i_dir,
  output logic [7:0] o_nextX,
  output logic       o_nextDir
);

  // Nine-bit arithmetic so x+X_STEP cannot wrap through 255 before the limit test.
  logic [8:0] w_sum;
  logic [8:0] w_lowBound;

  assign w_sum      = {1'b0, i_x} + 9'(X_STEP);
  assign w_lowBound = 9'(X_MIN) + 9'(X_STEP);

  always_comb begin
    o_nextX   = i_x;
    o_nextDir = i_dir;
    if (i_dir == GO_RIGHT) begin
      if (w_sum > 9'(X_MAX)) begin
`ifdef ROW_SEQ_BOUNCE_EN
        o_nextX   = 8'(X_MAX);
        o_nextDir = GO_LEFT;
`else
        o_nextX   = 8'(X_MIN);
`endif
      end else begin
        o_nextX = w_sum[7:0];
      end
    end else begin
      if ({1'b0, i_x} < w_lowBound) begin
`ifdef ROW_SEQ_BOUNCE_EN
        o_nextX   = 8'(X_MIN);
        o_nextDir = GO_RIGHT;
`else
        o_nextX   = 8'(X_MAX);
`endif
      end else begin
        o_nextX = i_x - 8'(X_STEP);
      end
    end
  end

endmodule

// File: rtl/row_sequencer.sv
// Row/position sequencer: row counter, row Y pixel, horizontal sweep and drop capture.
// Limit behaviour of the sweep is selected by ROW_SEQ_BOUNCE_EN (see row_seq_stepper).
module row_sequencer
  import tob_pkg::*;
#(
  parameter int NUM_ROWS   = 7,
  parameter int ROW_PITCH  = 16,
  parameter int Y_BOTTOM   = 104,
  parameter int X_MIN      = 0,
  parameter int X_MAX      = 144,
  parameter int X_STEP     = 4,
  parameter int SERPENTINE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       step,
  input  logic       drop,
  output logic [7:0] x_pos,
  output logic [6:0] y_pos,
  output logic       direction,
  output logic [4:0] row,
  output logic       active,
  output logic       row_done,
  output logic [7:0] drop_x,
  output logic       top_reached
);

  row_seq_state_t r_state;
  logic [7:0]     r_x;
  logic [6:0]     r_y;
  logic           r_dir;
  logic [4:0]     r_row;
  logic           r_active;
  logic           r_rowDone;
  logic [7:0]     r_dropX;
  logic           r_top;

  logic [7:0]     w_nextX;
  logic           w_nextDir;
  logic [4:0]     w_rowInc;

  assign w_rowInc = r_row + 5'd1;

  function automatic logic [6:0] rowY(input logic [4:0] r);
    logic [11:0] t;
    t = 12'(Y_BOTTOM) - 12'(r) * 12'(ROW_PITCH);
    return t[6:0];
  endfunction

  function automatic logic startLeft(input logic [4:0] r);
    return (SERPENTINE != 0) && r[0];
  endfunction

  row_seq_stepper #(
    .X_MIN (X_MIN),
    .X_MAX (X_MAX),
    .X_STEP(X_STEP)
  ) u_stepper (
    .i_x      (r_x),
    .i_dir    (r_dir),
    .o_nextX  (w_nextX),
    .o_nextDir(w_nextDir)
  );

  // start overrides everything; drop beats a same-cycle step in MOVE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_row     <= 5'd0;
      r_x       <= 8'(X_MIN);
      r_y       <= 7'(Y_BOTTOM);
      r_dir     <= GO_RIGHT;
      r_active  <= 1'b0;
      r_rowDone <= 1'b0;
      r_dropX   <= 8'd0;
      r_top     <= 1'b0;
    end else begin
      r_rowDone <= 1'b0;
      if (start) begin
        r_state  <= MOVE;
        r_row    <= 5'd0;
        r_x      <= 8'(X_MIN);
        r_dir    <= GO_RIGHT;
        r_y      <= rowY(5'd0);
        r_active <= 1'b1;
        r_top    <= 1'b0;
        r_dropX  <= 8'd0;
      end else begin
        case (r_state)
          MOVE: begin
            if (drop) begin
              r_dropX   <= r_x;
              r_rowDone <= 1'b1;
              r_active  <= 1'b0;
              r_state   <= ADVANCE;
            end else if (step) begin
              r_x   <= w_nextX;
              r_dir <= w_nextDir;
            end
          end
          ADVANCE: begin
            if (r_row == 5'(NUM_ROWS - 1)) begin
              r_state <= DONE;
              r_top   <= 1'b1;
            end else begin
              r_row    <= w_rowInc;
              r_y      <= rowY(w_rowInc);
              r_x      <= startLeft(w_rowInc) ? 8'(X_MAX) : 8'(X_MIN);
              r_dir    <= startLeft(w_rowInc) ? GO_LEFT : GO_RIGHT;
              r_active <= 1'b1;
              r_state  <= MOVE;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign x_pos       = r_x;
  assign y_pos       = r_y;
  assign direction   = r_dir;
  assign row         = r_row;
  assign active      = r_active;
  assign row_done    = r_rowDone;
  assign drop_x      = r_dropX;
  assign top_reached = r_top;

endmodule

// File: tb/tb_row_sequencer.sv
// Directed self-checking bench for row_sequencer with default geometry.
// Expectations for the limit step follow ROW_SEQ_BOUNCE_EN when it is defined.
module tb_row_sequencer;

  logic       clk;
  logic       reset;
  logic       start;
  logic       step;
  logic       drop;
  logic [7:0] x_pos;
  logic [6:0] y_pos;
  logic       direction;
  logic [4:0] row;
  logic       active;
  logic       row_done;
  logic [7:0] drop_x;
  logic       top_reached;

  int errorCount = 0;
  int checkCount = 0;

  row_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .step       (step),
    .drop       (drop),
    .x_pos      (x_pos),
    .y_pos      (y_pos),
    .direction  (direction),
    .row        (row),
    .active     (active),
    .row_done   (row_done),
    .drop_x     (drop_x),
    .top_reached(top_reached)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs from a falling edge; returns at the next falling edge.
  task automatic applyStimulus(input logic s, input logic st, input logic d);
    start = s;
    step  = st;
    drop  = d;
    @(negedge clk);
    start = 1'b0;
    step  = 1'b0;
    drop  = 1'b0;
  endtask

  task automatic idleCycle();
    @(negedge clk);
  endtask

  task automatic dropAndAdvance(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      idleCycle();
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " x"}, int'(x_pos), 0);
    checkOutput({tag, " y"}, int'(y_pos), 104);
    checkOutput({tag, " dir"}, int'(direction), 1);
    checkOutput({tag, " row"}, int'(row), 0);
    checkOutput({tag, " active"}, int'(active), 0);
    checkOutput({tag, " row_done"}, int'(row_done), 0);
    checkOutput({tag, " drop_x"}, int'(drop_x), 0);
    checkOutput({tag, " top"}, int'(top_reached), 0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    step  = 1'b0;
    drop  = 1'b0;
    repeat (3) @(negedge clk);
    checkResetValues("reset");
    reset = 1'b0;
    idleCycle();
    checkOutput("idle active", int'(active), 0);

    // Start: row 0 at the left edge moving right.
    applyStimulus(1'b1, 1'b0, 1'b0);
    idleCycle();
    checkOutput("start x", int'(x_pos), 0);
    checkOutput("start y", int'(y_pos), 104);
    checkOutput("start dir", int'(direction), 1);
    checkOutput("start row", int'(row), 0);
    checkOutput("start active", int'(active), 1);

    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("step1 x", int'(x_pos), 4);
    for (int i = 1; i < 36; i++) applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("step36 x", int'(x_pos), 144);
    checkOutput("step36 dir", int'(direction), 1);

    applyStimulus(1'b0, 1'b1, 1'b0);
`ifdef ROW_SEQ_BOUNCE_EN
    checkOutput("step37 x", int'(x_pos), 144);
    checkOutput("step37 dir", int'(direction), 0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("step38 x", int'(x_pos), 140);
    checkOutput("step38 dir", int'(direction), 0);
`else
    checkOutput("wrap x", int'(x_pos), 0);
    checkOutput("wrap dir", int'(direction), 1);
`endif

    // Restart mid-row, sweep to x=40, then drop with a same-cycle step.
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("pre-drop x", int'(x_pos), 40);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("drop row_done", int'(row_done), 1);
    checkOutput("drop drop_x", int'(drop_x), 40);
    checkOutput("drop active", int'(active), 0);
    checkOutput("drop row", int'(row), 0);
    idleCycle();
    checkOutput("adv row_done", int'(row_done), 0);
    checkOutput("row1 row", int'(row), 1);
    checkOutput("row1 y", int'(y_pos), 88);
    checkOutput("row1 x", int'(x_pos), 144);
    checkOutput("row1 dir", int'(direction), 0);
    checkOutput("row1 active", int'(active), 1);

    // Start arriving during ADVANCE restarts at row 0.
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("adv-start row", int'(row), 0);
    checkOutput("adv-start y", int'(y_pos), 104);
    checkOutput("adv-start active", int'(active), 1);

    // Climb the full tower.
    dropAndAdvance(6);
    checkOutput("row6 row", int'(row), 6);
    checkOutput("row6 y", int'(y_pos), 8);
    checkOutput("row6 x", int'(x_pos), 0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("drop7 row_done", int'(row_done), 1);
    idleCycle();
    checkOutput("done top", int'(top_reached), 1);
    checkOutput("done row", int'(row), 6);
    checkOutput("done y", int'(y_pos), 8);
    checkOutput("done active", int'(active), 0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("done drop row_done", int'(row_done), 0);
    checkOutput("done step x", int'(x_pos), 0);
    checkOutput("done drop_x held", int'(drop_x), 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("restart row", int'(row), 0);
    checkOutput("restart y", int'(y_pos), 104);
    checkOutput("restart top", int'(top_reached), 0);

    // Reach row 3, move once, then reset together with a drop.
    dropAndAdvance(3);
    checkOutput("row3 y", int'(y_pos), 56);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("row3 step x", int'(x_pos), 140);
    #2;
    reset = 1'b1;
    drop  = 1'b1;
    #1;
    checkResetValues("async reset");
    @(negedge clk);
    drop = 1'b0;
    checkOutput("reset held row_done", int'(row_done), 0);
    reset = 1'b0;
    idleCycle();
    checkOutput("post-reset active", int'(active), 0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
